// File: rtl/mmio_bridge_ws.sv
// mmio_bridge_ws: decodes the MicroBlaze IO bus into N_SLOTS subsystem slots.
// Each request goes through a registered request/response FSM, so a slot can
// stretch an access over several cycles. A timeout always releases the CPU.
//
// Ports:
//   clk, reset                 - single clock, async active-high reset
//   io_addr_strobe_i           - request valid pulse
//   io_rd_strobe_i/io_wr_strobe_i - operation (both set = write)
//   io_byte_en_i, io_addr_i, io_wr_data_i - request payload
//   io_rd_data_o, io_rdy_o, err_o - completion (1-cycle pulse) back to CPU
//   cs_o, wr_o, rd_o, addr_o, wr_data_o, byte_en_o - slot-side access
//   rd_data_i, ack_i           - slot responses (slot k at [32k+31:32k])
module mmio_bridge_ws #(
    parameter logic [31:0] BRG_BASE    = 32'hc000_0000,
    parameter int unsigned N_SLOTS     = 4,
    parameter int unsigned SLOT_ADDR_W = 5,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_addr_strobe_i,
    input  logic                   io_rd_strobe_i,
    input  logic                   io_wr_strobe_i,
    input  logic [3:0]             io_byte_en_i,
    input  logic [31:0]            io_addr_i,
    input  logic [31:0]            io_wr_data_i,
    output logic [31:0]            io_rd_data_o,
    output logic                   io_rdy_o,
    output logic [N_SLOTS-1:0]     cs_o,
    output logic                   wr_o,
    output logic                   rd_o,
    output logic [SLOT_ADDR_W-1:0] addr_o,
    output logic [31:0]            wr_data_o,
    output logic [3:0]             byte_en_o,
    input  logic [32*N_SLOTS-1:0]  rd_data_i,
    input  logic [N_SLOTS-1:0]     ack_i,
    output logic                   err_o
);

    localparam int unsigned SLOT_W = $clog2(N_SLOTS);
    localparam int unsigned HI_LSB = 2 + SLOT_ADDR_W + SLOT_W;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q;
    logic [SLOT_ADDR_W-1:0] addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             be_q;
    logic                   wr_q;
    logic                   err_q;
    logic [31:0]            rdata_q;
    logic [CNT_W-1:0]       cnt_q;

    logic        req, hit, dec_ok, active, timeout_hit;
    logic        sel_ack;
    logic [31:0] sel_data;
    logic        unused_addr;

    assign unused_addr = ^io_addr_i[1:0];

    assign req    = io_addr_strobe_i & (io_rd_strobe_i | io_wr_strobe_i);
    assign hit    = (io_addr_i[31:24] == BRG_BASE[31:24]);
    // Shift form keeps the check valid even when no spare bits remain.
    assign dec_ok = hit && ((io_addr_i[23:0] >> HI_LSB) == 24'd0);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Only the selected slot's ack/data is ever observed.
    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                sel_ack  = ack_i[k];
                sel_data = rd_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req && hit) state_d = dec_ok ? ACCESS : DONE;
            ACCESS:  state_d = sel_ack ? DONE : WAIT;
            WAIT:    if (sel_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req && hit) begin
                    slot_q  <= io_addr_i[2+SLOT_ADDR_W +: SLOT_W];
                    addr_q  <= io_addr_i[2 +: SLOT_ADDR_W];
                    wdata_q <= io_wr_data_i;
                    be_q    <= io_wr_strobe_i ? io_byte_en_i : 4'hF;
                    wr_q    <= io_wr_strobe_i;
                    err_q   <= !dec_ok;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                end
                ACCESS: begin
                    cnt_q <= CNT_W'(1);
                    if (sel_ack && !wr_q) rdata_q <= sel_data;
                end
                WAIT: begin
                    // Ack in the final cycle takes priority over the timeout.
                    if (sel_ack) begin
                        if (!wr_q) rdata_q <= sel_data;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign active = (state_q == ACCESS) || (state_q == WAIT);

    always_comb begin
        cs_o = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            cs_o[k] = active && (slot_q == SLOT_W'(k));
        end
    end

    assign wr_o         = (state_q == ACCESS) && wr_q;
    assign rd_o         = (state_q == ACCESS) && !wr_q;
    assign addr_o       = active ? addr_q  : '0;
    assign wr_data_o    = active ? wdata_q : '0;
    assign byte_en_o    = active ? be_q    : '0;
    assign io_rdy_o     = (state_q == DONE);
    assign io_rd_data_o = (state_q == DONE) ? rdata_q : '0;
    assign err_o        = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mmio_bridge_ws.sv
module tb_mmio_bridge_ws;

    logic         clk = 1'b0;
    logic         reset;
    logic         io_addr_strobe_i, io_rd_strobe_i, io_wr_strobe_i;
    logic [3:0]   io_byte_en_i;
    logic [31:0]  io_addr_i, io_wr_data_i, io_rd_data_o;
    logic         io_rdy_o, wr_o, rd_o, err_o;
    logic [3:0]   cs_o, byte_en_o, ack_i;
    logic [4:0]   addr_o;
    logic [31:0]  wr_data_o;
    logic [127:0] rd_data_i;

    int checks = 0;
    int errors = 0;

    // measurement results
    int          m_lat, m_cs_cnt, m_rd_cnt, m_wr_cnt, m_rdy_cnt;
    logic [31:0] m_data, m_wdata1;
    logic        m_err, m_wr1;
    logic [3:0]  m_cs1, m_be1;
    logic [4:0]  m_addr1;

    // second-strobe stimulus used by measure
    logic [31:0] x_addr, x_data;
    logic [3:0]  x_be;
    logic        x_wr, x_rd;

    mmio_bridge_ws #(
        .BRG_BASE(32'hc000_0000), .N_SLOTS(4), .SLOT_ADDR_W(5), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe_i(io_addr_strobe_i), .io_rd_strobe_i(io_rd_strobe_i),
        .io_wr_strobe_i(io_wr_strobe_i), .io_byte_en_i(io_byte_en_i),
        .io_addr_i(io_addr_i), .io_wr_data_i(io_wr_data_i),
        .io_rd_data_o(io_rd_data_o), .io_rdy_o(io_rdy_o),
        .cs_o(cs_o), .wr_o(wr_o), .rd_o(rd_o), .addr_o(addr_o),
        .wr_data_o(wr_data_o), .byte_en_o(byte_en_o),
        .rd_data_i(rd_data_i), .ack_i(ack_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic wr, input logic rd);
        io_addr_strobe_i = 1'b1;
        io_wr_strobe_i   = wr;
        io_rd_strobe_i   = rd;
        io_addr_i        = a;
        io_wr_data_i     = d;
        io_byte_en_i     = be;
        @(posedge clk); #1;
    endtask

    // Cycle 1 is the cycle right after the strobe was sampled.
    task automatic measure(input int budget, input logic [3:0] ack_base,
                           input int ack_at, input logic [3:0] ack_val, input int x_at);
        m_lat = 0; m_cs_cnt = 0; m_rd_cnt = 0; m_wr_cnt = 0; m_rdy_cnt = 0;
        m_data = '0; m_err = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            ack_i = (i == ack_at) ? ack_val : ack_base;
            if (i == x_at) begin
                io_addr_strobe_i = 1'b1; io_wr_strobe_i = x_wr; io_rd_strobe_i = x_rd;
                io_addr_i = x_addr; io_wr_data_i = x_data; io_byte_en_i = x_be;
            end else begin
                io_addr_strobe_i = 1'b0; io_wr_strobe_i = 1'b0; io_rd_strobe_i = 1'b0;
            end
            if (i == 1) begin
                m_cs1 = cs_o; m_addr1 = addr_o; m_wr1 = wr_o;
                m_wdata1 = wr_data_o; m_be1 = byte_en_o;
            end
            if (cs_o != 4'd0) m_cs_cnt++;
            if (rd_o) m_rd_cnt++;
            if (wr_o) m_wr_cnt++;
            if (io_rdy_o) begin
                m_rdy_cnt++;
                if (m_lat == 0) begin
                    m_lat = i; m_data = io_rd_data_o; m_err = err_o;
                end
            end
            @(posedge clk); #1;
        end
        ack_i = '0;
        io_addr_strobe_i = 1'b0; io_wr_strobe_i = 1'b0; io_rd_strobe_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_addr_strobe_i = 0; io_rd_strobe_i = 0; io_wr_strobe_i = 0;
        io_byte_en_i = 0; io_addr_i = 0; io_wr_data_i = 0; ack_i = 0;
        rd_data_i = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_0000};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({io_rd_data_o, io_rdy_o, cs_o, wr_o, rd_o, addr_o, wr_data_o, byte_en_o, err_o} !== 80'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b cs=%b rd_data=%h err=%b, required all zero",
                     io_rdy_o, cs_o, io_rd_data_o, err_o);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_zero_wait();
        issue(32'hC000_010C, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
        measure(8, 4'b0100, 0, 4'b0000, 0);
        checks++;
        if ({m_cs1, m_addr1, m_wr1, m_be1} !== {4'b0100, 5'd3, 1'b1, 4'b0011}) begin
            errors++;
            $display("FAIL wr_access: got cs=%b addr=%0d wr=%b be=%b, required 0100 3 1 0011",
                     m_cs1, m_addr1, m_wr1, m_be1);
        end
        checks++;
        if (m_wdata1 !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_data: got %h, required 12345678", m_wdata1);
        end
        checks++;
        if ({m_lat, m_rdy_cnt, m_wr_cnt, m_rd_cnt} !== {32'd2, 32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL wr_latency: got lat=%0d rdy=%0d wr=%0d rd=%0d, required 2 1 1 0",
                     m_lat, m_rdy_cnt, m_wr_cnt, m_rd_cnt);
        end
        checks++;
        if ({m_err, m_data} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL wr_resp: got err=%b data=%h, required 0 0", m_err, m_data);
        end
    endtask

    task automatic test_read_wait();
        issue(32'hC000_0080, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b1);
        measure(10, 4'b0000, 4, 4'b0010, 0);
        checks++;
        if ({m_cs1, m_be1} !== {4'b0010, 4'hF}) begin
            errors++; $display("FAIL rd_access: got cs=%b be=%b, required 0010 1111", m_cs1, m_be1);
        end
        checks++;
        if ({m_cs_cnt, m_rd_cnt, m_wr_cnt} !== {32'd4, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL rd_pulses: got cs_cycles=%0d rd=%0d wr=%0d, required 4 1 0",
                     m_cs_cnt, m_rd_cnt, m_wr_cnt);
        end
        checks++;
        if ({m_lat, m_rdy_cnt} !== {32'd5, 32'd1}) begin
            errors++; $display("FAIL rd_latency: got lat=%0d rdy=%0d, required 5 1", m_lat, m_rdy_cnt);
        end
        checks++;
        if ({m_err, m_data} !== {1'b0, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL rd_data: got err=%b data=%h, required 0 cafef00d", m_err, m_data);
        end
    endtask

    task automatic test_timeout();
        issue(32'hC000_0000, 32'd0, 4'b0000, 1'b0, 1'b1);
        measure(25, 4'b0000, 0, 4'b0000, 0);
        checks++;
        if ({m_cs_cnt, m_lat, m_rdy_cnt} !== {32'd16, 32'd17, 32'd1}) begin
            errors++;
            $display("FAIL to_timing: got cs_cycles=%0d lat=%0d rdy=%0d, required 16 17 1",
                     m_cs_cnt, m_lat, m_rdy_cnt);
        end
        checks++;
        if ({m_err, m_data} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL to_resp: got err=%b data=%h, required 1 0", m_err, m_data);
        end
        // ack in the last allowed cycle beats the timeout
        issue(32'hC000_0000, 32'd0, 4'b0000, 1'b0, 1'b1);
        measure(25, 4'b0000, 16, 4'b0001, 0);
        checks++;
        if ({m_cs_cnt, m_lat, m_rdy_cnt} !== {32'd16, 32'd17, 32'd1}) begin
            errors++;
            $display("FAIL to_lastack_timing: got cs_cycles=%0d lat=%0d rdy=%0d, required 16 17 1",
                     m_cs_cnt, m_lat, m_rdy_cnt);
        end
        checks++;
        if ({m_err, m_data} !== {1'b0, 32'h1111_0000}) begin
            errors++; $display("FAIL to_lastack_resp: got err=%b data=%h, required 0 11110000", m_err, m_data);
        end
    endtask

    task automatic test_decode();
        issue(32'hC000_0400, 32'd0, 4'b0000, 1'b0, 1'b1);
        measure(8, 4'b1111, 0, 4'b0000, 0);
        checks++;
        if ({m_lat, m_rdy_cnt, m_cs_cnt} !== {32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL dec_invalid: got lat=%0d rdy=%0d cs_cycles=%0d, required 1 1 0",
                     m_lat, m_rdy_cnt, m_cs_cnt);
        end
        checks++;
        if ({m_err, m_data} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL dec_invalid_resp: got err=%b data=%h, required 1 0", m_err, m_data);
        end
        issue(32'hC100_0000, 32'd0, 4'b1111, 1'b1, 1'b0);
        measure(20, 4'b1111, 0, 4'b0000, 0);
        checks++;
        if ({m_rdy_cnt, m_cs_cnt, m_wr_cnt} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL dec_miss: got rdy=%0d cs_cycles=%0d wr=%0d, required 0 0 0",
                     m_rdy_cnt, m_cs_cnt, m_wr_cnt);
        end
    endtask

    task automatic test_robustness();
        // strobe during WAIT is dropped
        x_addr = 32'hC000_010C; x_data = 32'h5555_AAAA; x_be = 4'hF; x_wr = 1'b1; x_rd = 1'b0;
        issue(32'hC000_0080, 32'd0, 4'b0000, 1'b0, 1'b1);
        measure(12, 4'b0000, 4, 4'b0010, 2);
        checks++;
        if ({m_rdy_cnt, m_wr_cnt, m_lat} !== {32'd1, 32'd0, 32'd5}) begin
            errors++;
            $display("FAIL wait_strobe: got rdy=%0d wr=%0d lat=%0d, required 1 0 5",
                     m_rdy_cnt, m_wr_cnt, m_lat);
        end
        checks++;
        if (m_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wait_strobe_data: got %h, required cafef00d", m_data);
        end
        // stray ack from slot 3 while slot 1 is selected
        issue(32'hC000_0084, 32'd0, 4'b0000, 1'b0, 1'b1);
        measure(10, 4'b1000, 3, 4'b1010, 0);
        checks++;
        if ({m_lat, m_cs_cnt, m_rdy_cnt} !== {32'd4, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL stray_ack: got lat=%0d cs_cycles=%0d rdy=%0d, required 4 3 1",
                     m_lat, m_cs_cnt, m_rdy_cnt);
        end
        checks++;
        if (m_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL stray_ack_data: got %h, required cafef00d", m_data);
        end
    endtask

    task automatic test_back_to_back();
        x_addr = 32'hC000_0104; x_data = 32'h0BAD_CAFE; x_be = 4'b1100; x_wr = 1'b1; x_rd = 1'b1;
        issue(32'hC000_010C, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
        measure(10, 4'b0100, 0, 4'b0000, 3);
        checks++;
        if ({m_rdy_cnt, m_wr_cnt, m_rd_cnt, m_cs_cnt} !== {32'd2, 32'd2, 32'd0, 32'd2}) begin
            errors++;
            $display("FAIL b2b: got rdy=%0d wr=%0d rd=%0d cs_cycles=%0d, required 2 2 0 2",
                     m_rdy_cnt, m_wr_cnt, m_rd_cnt, m_cs_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        int rdy_seen;
        issue(32'hC000_0080, 32'd0, 4'b0000, 1'b0, 1'b1);
        io_addr_strobe_i = 1'b0; io_rd_strobe_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({cs_o, rd_o} !== {4'b0010, 1'b0}) begin
            errors++; $display("FAIL rst_pre: got cs=%b rd=%b, required 0010 0", cs_o, rd_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({io_rd_data_o, io_rdy_o, cs_o, wr_o, rd_o, addr_o, wr_data_o, byte_en_o, err_o} !== 80'd0) begin
            errors++;
            $display("FAIL rst_mid: got cs=%b rdy=%b be=%b, required all zero", cs_o, io_rdy_o, byte_en_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (io_rdy_o || cs_o != 4'd0) rdy_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (rdy_seen !== 0) begin
            errors++; $display("FAIL rst_no_rdy: got %0d active cycles, required 0", rdy_seen);
        end
        issue(32'hC000_010C, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
        measure(8, 4'b0100, 0, 4'b0000, 0);
        checks++;
        if ({m_lat, m_rdy_cnt, m_err} !== {32'd2, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL rst_recover: got lat=%0d rdy=%0d err=%b, required 2 1 0",
                     m_lat, m_rdy_cnt, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_decode();
        test_robustness();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
